// File: rtl/tt_um_serdes_if.sv
// rtl/tt_um_serdes_if.sv - TinyTapeout harness bus for the serdes tile
interface tt_um_serdes_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, output uio_in, input uo_out, input uio_out, input uio_oe);
  modport slave  (input ui_in, input uio_in, output uo_out, output uio_out, output uio_oe);
endinterface

// File: rtl/tt_um_serdes.sv
// rtl/tt_um_serdes.sv - 10-bit framed serializer/deserializer, one bit per clock
module tt_um_serdes (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  tt_um_serdes_if.slave bus
);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rx_state_e;

  logic tx_load;
  logic serial_in;
  logic loopback;
  logic serial_out;
  logic tx_busy;
  logic rx_line;

  assign tx_load   = bus.uio_in[0];
  assign serial_in = bus.uio_in[1];
  assign loopback  = bus.uio_in[2];

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, bus.uio_in[7:3]};

  tx_state_e  tx_state_q, tx_state_d;
  logic [3:0] tx_cnt_q, tx_cnt_d;
  logic [9:0] tx_frame_q, tx_frame_d;
  logic       tx_done_q, tx_done_d;

  rx_state_e  rx_state_q, rx_state_d;
  logic [2:0] rx_cnt_q, rx_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       sync1_q, sync2_q;

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= 4'd0;
      tx_frame_q  <= 10'h3FF;
      tx_done_q   <= 1'b0;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_frame_q  <= tx_frame_d;
      tx_done_q   <= tx_done_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      sync1_q     <= rx_line;
      sync2_q     <= sync1_q;
    end
  end

  // Transmitter next state: frame shifts out LSB first; count 9 means the stop bit is on the line
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_frame_d = tx_frame_q;
    tx_done_d  = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_load) begin
          tx_state_d = TX_SHIFT;
          tx_frame_d = {1'b1, bus.ui_in, 1'b0};
          tx_cnt_d   = 4'd0;
        end
      end
      TX_SHIFT: begin
        tx_frame_d = {1'b1, tx_frame_q[9:1]};
        tx_cnt_d   = tx_cnt_q + 4'd1;
        if (tx_cnt_q == 4'd9) begin
          tx_state_d = TX_IDLE;
          tx_done_d  = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Receiver next state: samples the synchronized line once per clock, no oversampling
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!sync2_q) begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = 3'd0;
        end
      end
      RX_DATA: begin
        rx_shift_d = {sync2_q, rx_shift_q[7:1]};
        rx_cnt_d   = rx_cnt_q + 3'd1;
        if (rx_cnt_q == 3'd7) begin
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        rx_state_d = RX_IDLE;
        if (sync2_q) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    tx_busy     = (tx_state_q == TX_SHIFT);
    serial_out  = tx_busy ? tx_frame_q[0] : 1'b1;
    rx_line     = loopback ? serial_out : serial_in;
    bus.uo_out  = rx_data_q;
    bus.uio_out = {tx_done_q, frame_err_q, rx_valid_q, tx_busy, serial_out, 3'b000};
    bus.uio_oe  = 8'hF8;
  end

endmodule

// File: tb/tb_tt_um_serdes.sv
// tb/tb_tt_um_serdes.sv - self-checking bench for tt_um_serdes
module tb_tt_um_serdes;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;

  tt_um_serdes_if bus ();

  tt_um_serdes dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] last_good;

  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;
    logic [7:0] uo;
  } vec_t;

  vec_t vecs[5];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Line value t clocks after the load edge for a frame carrying d
  function automatic logic tx_bit(input logic [7:0] d, input int t);
    if (t == 0) return 1'b0;
    if (t >= 9) return 1'b1;
    return d[t-1];
  endfunction

  function automatic logic [7:0] exp_uio(input logic so, input logic busy, input logic valid,
                                         input logic err, input logic done);
    return {done, err, valid, busy, so, 3'b000};
  endfunction

  task automatic tx_loopback_frame(input logic [7:0] data, input logic [9:0] seq,
                                   input logic [7:0] exp_uo, input string tag);
    logic [7:0] e;
    bus.ui_in  = data;
    bus.uio_in = 8'b0000_0101;
    for (int c = 0; c <= 14; c++) begin
      tick();
      if (c == 0) begin
        bus.uio_in[0] = 1'b0;
        bus.ui_in     = ~data;
      end
      e = exp_uio((c <= 9) ? seq[c] : 1'b1, c <= 9, c == 12, 1'b0, c == 10);
      check8($sformatf("%s uio_out c%0d", tag, c), bus.uio_out, e);
      if (c == 12 || c == 14) check8($sformatf("%s uo_out c%0d", tag, c), bus.uo_out, exp_uo);
    end
    last_good = exp_uo;
  endtask

  task automatic rx_ext_frame(input logic [9:0] bits, input string tag);
    logic [7:0] e;
    bus.uio_in = 8'b0000_0000;
    for (int c = 0; c <= 13; c++) begin
      bus.uio_in[1] = (c <= 9) ? bits[c] : 1'b1;
      tick();
      if (c == 11 && bits[9] && !bits[0]) last_good = bits[8:1];
      e = exp_uio(1'b1, 1'b0, c == 11 && bits[9], c == 11 && !bits[9], 1'b0);
      check8($sformatf("%s uio_out c%0d", tag, c), bus.uio_out, e);
      if (c == 11 || c == 13) check8($sformatf("%s uo_out c%0d", tag, c), bus.uo_out, last_good);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [9:0] s;
    logic       stop;
    int         pulses;

    vecs[0] = '{8'hA5, 10'b1101001010, 8'hA5};
    vecs[1] = '{8'h3C, 10'b1001111000, 8'h3C};
    vecs[2] = '{8'h00, 10'b1000000000, 8'h00};
    vecs[3] = '{8'hFF, 10'b1111111110, 8'hFF};
    vecs[4] = '{8'h81, 10'b1100000010, 8'h81};

    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    last_good  = 8'h00;

    // Reset values while held, then after release
    repeat (3) @(negedge clk);
    check8("reset uo_out", bus.uo_out, 8'h00);
    check8("reset uio_out", bus.uio_out, 8'h08);
    check8("reset uio_oe", bus.uio_oe, 8'hF8);
    rst_n = 1'b1;
    tick();
    check8("post-reset uio_out", bus.uio_out, 8'h08);

    // Reset asserted mid-frame in both directions
    bus.ui_in  = 8'hFF;
    bus.uio_in = 8'b0000_0101;
    tick();
    bus.uio_in[0] = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check8("mid-frame reset uio_out", bus.uio_out, 8'h08);
    check8("mid-frame reset uo_out", bus.uo_out, 8'h00);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.uio_out !== 8'h08) pulses++;
    end
    check8("post-abort stray activity", pulses[7:0], 8'h00);
    check8("post-abort uo_out", bus.uo_out, 8'h00);

    for (int i = 0; i < 5; i++)
      tx_loopback_frame(vecs[i].data, vecs[i].seq, vecs[i].uo, $sformatf("vec%0d", i));

    rx_ext_frame(10'b1000011110, "ext 0x0F");

    for (int i = 0; i < 8; i++) begin
      d    = 8'($urandom);
      stop = 1'($urandom_range(0, 3) != 0);
      rx_ext_frame({stop, d, 1'b0}, $sformatf("ext rand%0d", i));
    end

    // Line stuck low: a framing error every 10 clocks, output untouched
    bus.uio_in = 8'h00;
    for (int c = 0; c <= 41; c++) begin
      tick();
      check8($sformatf("stuck-low uio_out c%0d", c), bus.uio_out,
             exp_uio(1'b1, 1'b0, 1'b0, c >= 11 && (c - 11) % 10 == 0, 1'b0));
    end
    check8("stuck-low uo_out", bus.uo_out, last_good);

    bus.uio_in = 8'b0000_0010;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    last_good = 8'h00;
    tick();
    check8("re-reset uo_out", bus.uo_out, 8'h00);

    // Back-to-back frames with tx_load held high
    bus.ui_in  = 8'h55;
    bus.uio_in = 8'b0000_0101;
    for (int c = 0; c <= 24; c++) begin
      logic so, busy;
      tick();
      if (c == 3) bus.ui_in = 8'hAA;
      if (c == 11) bus.uio_in[0] = 1'b0;
      if (c <= 9) begin
        so = tx_bit(8'h55, c);
        busy = 1'b1;
      end else if (c >= 11 && c <= 20) begin
        so = tx_bit(8'hAA, c - 11);
        busy = 1'b1;
      end else begin
        so = 1'b1;
        busy = 1'b0;
      end
      check8($sformatf("b2b uio_out c%0d", c), bus.uio_out,
             exp_uio(so, busy, c == 12 || c == 23, 1'b0, c == 10 || c == 21));
      if (c == 12) check8("b2b first byte", bus.uo_out, 8'h55);
      if (c == 23) check8("b2b second byte", bus.uo_out, 8'hAA);
    end
    last_good = 8'hAA;

    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      for (int t = 0; t < 10; t++) s[t] = tx_bit(d, t);
      tx_loopback_frame(d, s, d, $sformatf("loop rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_um_serdes.md
# tt_um_serdes

Single-clock serializer/deserializer tile for the TinyTapeout harness. The transmitter takes a parallel byte from the dedicated inputs and emits a 10-bit framed serial stream at one bit per clock. The receiver recovers framed bytes from an external serial pin, or from its own transmitter in loopback, and presents them on the dedicated outputs.

## Interface
- No parameters. Frame format is fixed: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Bit rate is one bit per `clk`.
- `clk` input 1: single clock. All state is on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `ena` input 1: harness enable. Ignored; the design always runs.
- `ui_in` input 8: TX parallel byte. Sampled only on an accepted load.
- `uio_in` input 8:
  - [0] `tx_load`: level request to start a frame.
  - [1] `serial_in`: external RX line, idle high.
  - [2] `loopback`: 1 routes internal `serial_out` to the RX instead of `serial_in`.
  - [7:3] unused.
- `uo_out` output 8: last correctly received byte.
- `uio_out` output 8:
  - [2:0] = 0.
  - [3] `serial_out`: TX line, idle high.
  - [4] `tx_busy`.
  - [5] `rx_valid`: 1-cycle pulse.
  - [6] `frame_err`: 1-cycle pulse.
  - [7] `tx_done`: 1-cycle pulse.
- `uio_oe` output 8: constant 8'b1111_1000.

## Operation
- TX states are IDLE and SHIFT, with a 4-bit bit counter and a 10-bit frame register.
  - IDLE: `serial_out`=1, `tx_busy`=0.
  - Accepted load: a rising edge where `tx_load`=1 and IDLE. The frame register becomes {1, `ui_in`, 0}, the state goes to SHIFT, and the count is cleared.
  - SHIFT: the frame register LSB drives `serial_out`. Each edge shifts right and increments the count.
  - After the stop bit has been driven for one cycle, the state returns to IDLE and `tx_done` pulses for 1 cycle.
  - `tx_load` is ignored while busy. If `tx_load` is held high, the next frame starts at the first IDLE edge, giving one idle-high cycle between frames.
- RX input path:
  - The line source is `loopback ? serial_out : serial_in`.
  - It passes through a 2-flop synchronizer; both flops reset to 1.
- RX states are IDLE, DATA and STOP.
  - IDLE: when the synchronized line is sampled 0, go to DATA with count=0.
  - DATA: on each of the next 8 edges, shift the sampled bit in at the MSB of an 8-bit shift register (right shift), which gives LSB-first order. After 8 bits, go to STOP.
  - STOP: sample one bit.
    - If 1: `uo_out` is loaded with the shift register and `rx_valid` pulses.
    - If 0: `frame_err` pulses and `uo_out` is unchanged.
    - In both cases, return to IDLE.
  - A line held low after a frame error is treated as a new start bit on the next edge sampled in IDLE.
- There is no oversampling. External `serial_in` must be driven synchronous to `clk`, at one bit per cycle.
- TX and RX operate independently and concurrently.

## Timing
- Reset values:
  - `uo_out`=0x00.
  - `serial_out`=1.
  - `tx_busy`=0, `rx_valid`=0, `frame_err`=0, `tx_done`=0.
  - Synchronizer flops = 1.
  - Both FSMs in IDLE.
  - `uio_oe` is constant.
- An asserted reset mid-frame aborts both directions immediately. After release, no partial byte or pulse is produced.
- TX timing, with the accepted load on edge E0:
  - Start bit is on `serial_out` after E0.
  - Data bit k is on `serial_out` after E(1+k).
  - Stop bit is on `serial_out` after E9.
  - `tx_busy`=1 from after E0 through after E9, i.e. 10 cycles.
  - After E10: `tx_busy`=0 and `tx_done`=1 for that one cycle.
- RX line timing:
  - A line bit reaches the FSM 2 edges after it appears at the source.
  - The start bit is detected at the 3rd edge.
  - Data bit k is sampled at edge 4+k.
  - The stop bit is sampled at edge 12.
  - `uo_out` and `rx_valid` update after edge 12.
- Loopback latency: `rx_valid` is high during the cycle after E12, i.e. 12 cycles after the load edge.
- Pulses are exactly one cycle wide.

## Test plan
- Reset: assert `rst_n`=0 mid-frame, then release. Required: `uo_out`=0x00, `uio_out`=0x08 (`serial_out`=1, all else 0), `uio_oe`=0xF8.
- TX frame: `ui_in`=0xA5 with a 1-cycle `tx_load`. Required:
  - `serial_out` sequence is 0,1,0,1,0,0,1,0,1,1.
  - `tx_busy` is high for 10 cycles.
  - `tx_done` pulses once.
- Loopback: `loopback`=1, send 0x3C. Required:
  - `rx_valid` pulses exactly 12 cycles after the load edge.
  - `uo_out`=0x3C and it holds afterwards.
- External RX: drive `serial_in` with 0,1,1,1,1,0,0,0,0,1 (0x0F), one bit per cycle. Required: `uo_out`=0x0F with one `rx_valid` pulse.
- Framing error: drive `serial_in` low continuously. Required:
  - `frame_err` pulses every 10 cycles.
  - `rx_valid` never asserts.
  - `uo_out` is unchanged.
- Back-to-back: hold `tx_load`=1 across two frames, changing `ui_in` from 0x55 to 0xAA during the first frame. Required:
  - The second frame carries the `ui_in` value present at its own load edge, 0xAA.
  - There is one idle-high cycle between the two frames.
  - The loopback receiver reports 0x55 then 0xAA.
